// File: rtl/s3_chien_forney_pkg.sv
// Shared definitions for the RS(255,251) stage-3 Chien search / Forney block:
// field constants, FSM state type and GF(2^8) helper functions.
package s3_chien_forney_pkg;

    localparam logic [8:0] GF_PRIM_POLY = 9'h11D;
    localparam int         T            = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } cs_state_e;

    // Multiply by alpha: shift left and reduce by the primitive polynomial.
    function automatic logic [7:0] gf_mul_a(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_PRIM_POLY[7:0] : 8'h00);
    endfunction

    // Multiply by alpha^2.
    function automatic logic [7:0] gf_mul_a2(input logic [7:0] a);
        return gf_mul_a(gf_mul_a(a));
    endfunction

    // Multiply by alpha^-1 (alpha^254): shift right, folding the polynomial back in when bit 0 is set.
    function automatic logic [7:0] gf_mul_ainv(input logic [7:0] a);
        return a[0] ? {1'b1, a[7:1] ^ GF_PRIM_POLY[7:1]} : {1'b0, a[7:1]};
    endfunction

    // General GF(2^8) product by shift-and-add.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? s : 8'h00);
            s = gf_mul_a(s);
        end
        return p;
    endfunction

    // base^e by square-and-multiply over the low 16 exponent bits.
    function automatic logic [7:0] gf_pow(input logic [7:0] base, input int e);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = base;
        for (int i = 0; i < 16; i++) begin
            r = e[i] ? gf_mul_const(r, s) : r;
            s = gf_mul_const(s, s);
        end
        return r;
    endfunction

    // Degree of the error locator (lambda0 does not affect it).
    function automatic logic [1:0] gf_lambda_deg(input logic [7:0] l1, input logic [7:0] l2);
        return (l2 != 8'h00) ? 2'd2 : ((l1 != 8'h00) ? 2'd1 : 2'd0);
    endfunction

endpackage

// File: rtl/gf2m8_inv.sv
// Combinational GF(2^8) inverse (a^254); zero maps to zero.
module gf2m8_inv
    import s3_chien_forney_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    // Inverse via exponentiation, with the zero input pinned to zero.
    always_comb begin
        y_o = (a_i == 8'h00) ? 8'h00 : gf_pow(a_i, 254);
    end

endmodule

// File: rtl/gf2m8_multi.sv
// Combinational GF(2^8) multiplier, primitive polynomial 0x11D.
module gf2m8_multi
    import s3_chien_forney_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);

    // Full product of the two operands.
    always_comb begin
        p_o = gf_mul_const(a_i, b_i);
    end

endmodule

// File: rtl/s3_chien_forney.sv
// Stage 3 of the t=2 RS(255,251) decoder: serial Chien search from position
// N-1 down to 0 with Forney error values, one registered result per cycle.
// Optional macro S3_CS_OVERRUN_EN adds the cs_overrun pulse output that flags
// a kes_done arriving while the block is busy.
//
// The position reported in a cycle is evaluated one cycle earlier, so the
// Chien registers always run one position ahead of cs_pos. In LOAD the first
// position (N-1) is evaluated directly from the initial-value multipliers.
module s3_chien_forney
    import s3_chien_forney_pkg::*;
#(
    parameter int N = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kes_done,
    input  logic [7:0] rs_lambda0,
    input  logic [7:0] rs_lambda1,
    input  logic [7:0] rs_lambda2,
    input  logic [7:0] rs_omega0,
    input  logic [7:0] rs_omega1,
    output logic       cs_sym_vld,
    output logic [7:0] cs_pos,
    output logic       cs_err,
    output logic [7:0] cs_err_val,
    output logic       cs_done,
    output logic [1:0] cs_err_cnt,
    output logic       cs_fail
`ifdef S3_CS_OVERRUN_EN
    ,
    output logic       cs_overrun
`endif
);

    localparam logic [7:0] K_C1    = gf_pow(8'h02, (255 - (N - 1)) % 255);
    localparam logic [7:0] K_C2    = gf_pow(8'h02, (2 * (255 - (N - 1))) % 255);
    localparam logic [7:0] K_X0    = gf_pow(8'h02, N - 1);
    localparam logic [7:0] POS_TOP = 8'(N - 1);
    localparam logic [1:0] CNT_MAX = 2'(T + 1);

    cs_state_e  state_q, state_d;
    logic [7:0] l0_q, l0_d, l1_q, l1_d, l2_q, l2_d;
    logic [7:0] w0_q, w0_d, om1_q, om1_d;
    logic [7:0] c1_q, c1_d, c2_q, c2_d, w1_q, w1_d, x_q, x_d;
    logic       vld_q, vld_d, err_q, err_d, done_q, done_d, fail_q, fail_d;
    logic [7:0] pos_q, pos_d, val_q, val_d;
    logic [1:0] cnt_q, cnt_d;

    logic [7:0] c1_init_s, c2_init_s, w1_init_s;
    logic [7:0] eval_c1_s, eval_c2_s, eval_w1_s, eval_x_s;
    logic [7:0] om_s, xom_s, val_raw_s, inv_l1_s, err_val_s;
    logic       root_s, fail_s;
    logic [1:0] cnt_next_s;

    gf2m8_multi u_mul_c1  (.a_i(l1_q),     .b_i(K_C1),     .p_o(c1_init_s));
    gf2m8_multi u_mul_c2  (.a_i(l2_q),     .b_i(K_C2),     .p_o(c2_init_s));
    gf2m8_multi u_mul_w1  (.a_i(om1_q),    .b_i(K_C1),     .p_o(w1_init_s));
    gf2m8_multi u_mul_xo  (.a_i(eval_x_s), .b_i(om_s),     .p_o(xom_s));
    gf2m8_multi u_mul_val (.a_i(xom_s),    .b_i(inv_l1_s), .p_o(val_raw_s));
    gf2m8_inv   u_inv     (.a_i(l1_q),     .y_o(inv_l1_s));

    // Evaluate Lambda and the Forney value for the next position to report.
    always_comb begin
        eval_c1_s  = (state_q == LOAD) ? c1_init_s : c1_q;
        eval_c2_s  = (state_q == LOAD) ? c2_init_s : c2_q;
        eval_w1_s  = (state_q == LOAD) ? w1_init_s : w1_q;
        eval_x_s   = (state_q == LOAD) ? K_X0      : x_q;
        om_s       = w0_q ^ eval_w1_s;
        root_s     = ((l0_q ^ eval_c1_s ^ eval_c2_s) == 8'h00);
        err_val_s  = root_s ? val_raw_s : 8'h00;
        cnt_next_s = (root_s && (cnt_q != CNT_MAX)) ? (cnt_q + 2'd1) : cnt_q;
        fail_s     = (cnt_q != gf_lambda_deg(l1_q, l2_q)) ||
                     ((l1_q == 8'h00) && (l2_q != 8'h00));
    end

    // FSM next state, coefficient latch, Chien stepping and result outputs.
    always_comb begin
        state_d = state_q;
        l0_d    = l0_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        w0_d    = w0_q;
        om1_d   = om1_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        w1_d    = w1_q;
        x_d     = x_q;
        vld_d   = 1'b0;
        pos_d   = 8'h00;
        err_d   = 1'b0;
        val_d   = 8'h00;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: begin
                if (kes_done) begin
                    l0_d    = rs_lambda0;
                    l1_d    = rs_lambda1;
                    l2_d    = rs_lambda2;
                    w0_d    = rs_omega0;
                    om1_d   = rs_omega1;
                    cnt_d   = 2'd0;
                    fail_d  = 1'b0;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                vld_d   = 1'b1;
                pos_d   = POS_TOP;
                err_d   = root_s;
                val_d   = err_val_s;
                cnt_d   = cnt_next_s;
                c1_d    = gf_mul_a(eval_c1_s);
                c2_d    = gf_mul_a2(eval_c2_s);
                w1_d    = gf_mul_a(eval_w1_s);
                x_d     = gf_mul_ainv(eval_x_s);
                state_d = SCAN;
            end
            SCAN: begin
                if (pos_q == 8'h00) begin
                    done_d  = 1'b1;
                    fail_d  = fail_s;
                    state_d = DONE;
                end else begin
                    vld_d   = 1'b1;
                    pos_d   = pos_q - 8'h01;
                    err_d   = root_s;
                    val_d   = err_val_s;
                    cnt_d   = cnt_next_s;
                    c1_d    = gf_mul_a(eval_c1_s);
                    c2_d    = gf_mul_a2(eval_c2_s);
                    w1_d    = gf_mul_a(eval_w1_s);
                    x_d     = gf_mul_ainv(eval_x_s);
                    state_d = SCAN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, coefficient, Chien and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            l0_q    <= 8'h00;
            l1_q    <= 8'h00;
            l2_q    <= 8'h00;
            w0_q    <= 8'h00;
            om1_q   <= 8'h00;
            c1_q    <= 8'h00;
            c2_q    <= 8'h00;
            w1_q    <= 8'h00;
            x_q     <= 8'h00;
            vld_q   <= 1'b0;
            pos_q   <= 8'h00;
            err_q   <= 1'b0;
            val_q   <= 8'h00;
            done_q  <= 1'b0;
            cnt_q   <= 2'd0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            w0_q    <= w0_d;
            om1_q   <= om1_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            w1_q    <= w1_d;
            x_q     <= x_d;
            vld_q   <= vld_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
            val_q   <= val_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

    assign cs_sym_vld = vld_q;
    assign cs_pos     = pos_q;
    assign cs_err     = err_q;
    assign cs_err_val = val_q;
    assign cs_done    = done_q;
    assign cs_err_cnt = cnt_q;
    assign cs_fail    = fail_q;

`ifdef S3_CS_OVERRUN_EN
    logic ovr_q, ovr_d;

    // Flag a start pulse that arrives while a scan is in progress.
    always_comb begin
        ovr_d = kes_done && (state_q != IDLE);
    end

    // Overrun pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign cs_overrun = ovr_q;
`endif

endmodule

// File: tb/tb_s3_chien_forney.sv
// Self-checking bench for s3_chien_forney: directed and random locator /
// evaluator sets compared against a log/antilog-table polynomial model.
module tb_s3_chien_forney;

    localparam int N = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       kes_done;
    logic [7:0] rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1;
    logic       cs_sym_vld, cs_err, cs_done, cs_fail;
    logic [7:0] cs_pos, cs_err_val;
    logic [1:0] cs_err_cnt;
`ifdef S3_CS_OVERRUN_EN
    logic       cs_overrun;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] gexp [0:254];
    int         glog [0:255];

    always #5 clk = ~clk;

    s3_chien_forney #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .kes_done   (kes_done),
        .rs_lambda0 (rs_lambda0),
        .rs_lambda1 (rs_lambda1),
        .rs_lambda2 (rs_lambda2),
        .rs_omega0  (rs_omega0),
        .rs_omega1  (rs_omega1),
        .cs_sym_vld (cs_sym_vld),
        .cs_pos     (cs_pos),
        .cs_err     (cs_err),
        .cs_err_val (cs_err_val),
        .cs_done    (cs_done),
        .cs_err_cnt (cs_err_cnt),
        .cs_fail    (cs_fail)
`ifdef S3_CS_OVERRUN_EN
        ,
        .cs_overrun (cs_overrun)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] apow(input int e);
        return gexp[e % 255];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        return gexp[(255 - glog[a]) % 255];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " vld"},  32'(cs_sym_vld), 32'd0);
        check_eq({tag, " pos"},  32'(cs_pos),     32'd0);
        check_eq({tag, " err"},  32'(cs_err),     32'd0);
        check_eq({tag, " val"},  32'(cs_err_val), 32'd0);
        check_eq({tag, " done"}, 32'(cs_done),    32'd0);
        check_eq({tag, " cnt"},  32'(cs_err_cnt), 32'd0);
        check_eq({tag, " fail"}, 32'(cs_fail),    32'd0);
`ifdef S3_CS_OVERRUN_EN
        check_eq({tag, " ovr"},  32'(cs_overrun), 32'd0);
`endif
    endtask

    // Starts at a negedge with the block idle; inj>0 pulses junk kes_done in that cycle.
    task automatic run_case(input string name, input logic [7:0] l0, input logic [7:0] l1,
                            input logic [7:0] l2, input logic [7:0] o0, input logic [7:0] o1,
                            input int inj);
        logic       e_err [0:N-1];
        logic [7:0] e_val [0:N-1];
        logic [7:0] ev, om;
        int         cnt, deg, pos;
        logic       e_fail, in_scan;
        cnt = 0;
        for (int j = 0; j < N; j++) begin
            ev       = l0 ^ gmul(l1, apow(255 - j)) ^ gmul(l2, apow(2 * (255 - j)));
            om       = o0 ^ gmul(o1, apow(255 - j));
            e_err[j] = (ev == 8'h00);
            e_val[j] = (e_err[j] && l1 != 8'h00) ? gmul(gmul(apow(j), om), ginv(l1)) : 8'h00;
            if (e_err[j]) cnt++;
        end
        if (cnt > 3) cnt = 3;
        deg    = (l2 != 8'h00) ? 2 : ((l1 != 8'h00) ? 1 : 0);
        e_fail = (cnt != deg) || (l1 == 8'h00 && deg == 2);

        rs_lambda0 = l0; rs_lambda1 = l1; rs_lambda2 = l2;
        rs_omega0  = o0; rs_omega1  = o1;
        kes_done   = 1'b1;
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            if (c == 1 || c == inj + 1) kes_done = 1'b0;
            pos     = N + 1 - c;
            in_scan = (c >= 2 && c <= N + 1);
            check_eq($sformatf("%s vld c%0d", name, c), 32'(cs_sym_vld), 32'(in_scan));
            if (in_scan) begin
                check_eq($sformatf("%s pos c%0d", name, c), 32'(cs_pos), 32'(pos));
                check_eq($sformatf("%s err p%0d", name, pos), 32'(cs_err), 32'(e_err[pos]));
                check_eq($sformatf("%s val p%0d", name, pos), 32'(cs_err_val), 32'(e_val[pos]));
            end else begin
                check_eq($sformatf("%s err c%0d", name, c), 32'(cs_err), 32'd0);
                check_eq($sformatf("%s val c%0d", name, c), 32'(cs_err_val), 32'd0);
            end
            check_eq($sformatf("%s done c%0d", name, c), 32'(cs_done), 32'(c == N + 2));
            if (c == 1) begin
                check_eq($sformatf("%s cnt cleared", name), 32'(cs_err_cnt), 32'd0);
                check_eq($sformatf("%s fail cleared", name), 32'(cs_fail), 32'd0);
            end
            if (c >= N + 2) begin
                check_eq($sformatf("%s cnt c%0d", name, c), 32'(cs_err_cnt), 32'(cnt));
                check_eq($sformatf("%s fail c%0d", name, c), 32'(cs_fail), 32'(e_fail));
            end
`ifdef S3_CS_OVERRUN_EN
            check_eq($sformatf("%s ovr c%0d", name, c), 32'(cs_overrun), 32'(inj != 0 && c == inj + 1));
`endif
            if (inj != 0 && c == inj) begin
                rs_lambda0 = ~l0; rs_lambda1 = ~l1; rs_lambda2 = ~l2;
                rs_omega0  = ~o0; rs_omega1  = ~o1;
                kes_done   = 1'b1;
            end
        end
    endtask

    // Reset asserted in cycle 100 of a scan; scan must vanish without cs_done.
    task automatic reset_mid();
        int dones, vlds;
        rs_lambda0 = 8'h01; rs_lambda1 = 8'h20; rs_lambda2 = 8'h00;
        rs_omega0  = 8'h5A; rs_omega1  = 8'h00;
        kes_done   = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) kes_done = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrst");
        dones = 0;
        vlds  = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (cs_done)    dones++;
            if (cs_sym_vld) vlds++;
        end
        check_eq("midrst no done", 32'(dones), 32'd0);
        check_eq("midrst no vld",  32'(vlds),  32'd0);
    endtask

    initial begin
        logic [8:0] v;
        v = 9'h001;
        for (int i = 0; i < 255; i++) begin
            gexp[i]       = v[7:0];
            glog[v[7:0]]  = i;
            v = {v[7:0], 1'b0};
            if (v[8]) v = v ^ 9'h11D;
        end
        glog[0] = 0;

        rst = 1'b1; kes_done = 1'b0;
        rs_lambda0 = 8'h00; rs_lambda1 = 8'h00; rs_lambda2 = 8'h00;
        rs_omega0  = 8'h00; rs_omega1  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        run_case("single",  8'h01, 8'h20, 8'h00, 8'h5A, 8'h00, 0);
        run_case("double",  8'h01, 8'h03, 8'h02, 8'h00, 8'h03, 0);
        run_case("none",    8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        run_case("repeat",  8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 0);
        run_case("allzero", 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 0);
        run_case("busy50",  8'h01, 8'h03, 8'h02, 8'h00, 8'h03, 50);
        run_case("busydn",  8'h01, 8'h20, 8'h00, 8'h5A, 8'h00, N + 2);
        reset_mid();
        run_case("afterrst", 8'h01, 8'h20, 8'h00, 8'h5A, 8'h00, 0);

        for (int k = 0; k < 8; k++) begin
            logic [7:0] a, b, r0, r1;
            int mode;
            mode = $urandom_range(0, 3);
            a  = apow($urandom_range(0, N - 1));
            b  = apow($urandom_range(0, N - 1));
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            case (mode)
                0:       run_case("rnd1",   8'h01, a,     8'h00,     r0, r1, 0);
                1:       run_case("rnd2",   8'h01, a ^ b, gmul(a, b), r0, r1, 0);
                2:       run_case("rndrep", 8'h01, 8'h00, gmul(a, a), r0, r1, 0);
                default: run_case("rndany", 8'($urandom), 8'($urandom), 8'($urandom), r0, r1, 0);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
